icache_fill: RTL and testbench

ICACHE_FILL -- requirements
Module: icache_fill

---
 rtl/icache_fill.sv | 143 ++++++++++++++
 tb/tb_icache_fill.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// Direct-mapped 4 KiB instruction cache fill engine: 128 lines x 32 bytes,
// one-cycle lookup, ascending 8-beat line fill over a single-word bus.
module icache_fill (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic [31:0] itlbpa,
  input  logic        icfill,
  output logic [31:0] icinstr,
  output logic [20:0] ictag,
  output logic        icbusy,
  output logic        icerror,
  output logic        memreq,
  output logic [31:0] memaddr,
  input  logic        memack,
  input  logic [31:0] memrdata,
  input  logic        memerr
);

  typedef enum logic [1:0] {INIT, IDLE, REQ, ERR} state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic [2:0]  beat;
  logic [26:0] line;

  logic [31:0]  data [1024];
  logic [19:0]  tags [128];
  logic [127:0] valid;

  logic        data_we;
  logic [9:0]  data_wa;
  logic        vwe;
  logic        vwd;
  logic [6:0]  vwa;
  logic        tag_we;
  logic        unused_bits;

  assign unused_bits = ^{pc[63:12], pc[1:0], itlbpa[11:0]};

  assign memaddr = {line, beat, 2'b00};
  assign data_we = !reset && (state == REQ) && memack && !memerr;
  assign data_wa = {line[6:0], beat};

  // One valid-bit write port shared by the init sweep, fill start and fill completion.
  always_comb begin
    vwe    = 1'b0;
    vwd    = 1'b0;
    vwa    = cnt;
    tag_we = 1'b0;
    if (!reset) begin
      case (state)
        INIT: vwe = 1'b1;
        IDLE: begin
          if (icfill) begin
            vwe = 1'b1;
            vwa = pc[11:5];
          end
        end
        REQ: begin
          if (data_we && (beat == 3'd7)) begin
            vwe    = 1'b1;
            vwd    = 1'b1;
            vwa    = line[6:0];
            tag_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data[data_wa] <= memrdata;
    if (tag_we)  tags[vwa] <= line[26:7];
    if (vwe)     valid[vwa] <= vwd;
  end

  // Lookup forwards a same-cycle write so the read port behaves write-first.
  always_ff @(posedge clk) begin
    if (reset) begin
      icinstr <= 32'd0;
      ictag   <= 21'd0;
    end else begin
      icinstr     <= (data_we && (data_wa == pc[11:2])) ? memrdata : data[pc[11:2]];
      ictag[20]   <= (vwe && (vwa == pc[11:5])) ? vwd : valid[pc[11:5]];
      ictag[19:0] <= (tag_we && (vwa == pc[11:5])) ? line[26:7] : tags[pc[11:5]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      cnt     <= 7'd0;
      beat    <= 3'd0;
      icerror <= 1'b0;
      memreq  <= 1'b0;
      icbusy  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) begin
            state  <= IDLE;
            icbusy <= 1'b0;
          end
        end
        IDLE: begin
          if (icfill) begin
            line    <= {itlbpa[31:12], pc[11:5]};
            icerror <= 1'b0;
            beat    <= 3'd0;
            state   <= REQ;
            memreq  <= 1'b1;
            icbusy  <= 1'b1;
          end
        end
        REQ: begin
          if (memack) begin
            if (memerr) begin
              icerror <= 1'b1;
              state   <= ERR;
              memreq  <= 1'b0;
            end else begin
              beat <= beat + 3'd1;
              if (beat == 3'd7) begin
                state  <= IDLE;
                memreq <= 1'b0;
                icbusy <= 1'b0;
              end
            end
          end
        end
        ERR: begin
          state  <= IDLE;
          icbusy <= 1'b0;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill: a bus responder drives fills while a
// plain array model of lines, tags and valid bits predicts every lookup.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] itlbpa;
  logic        icfill;
  logic [31:0] icinstr;
  logic [20:0] ictag;
  logic        icbusy;
  logic        icerror;
  logic        memreq;
  logic [31:0] memaddr;
  logic        memack;
  logic [31:0] memrdata;
  logic        memerr;

  always #5 clk = ~clk;

  icache_fill dut (
    .clk(clk), .reset(reset), .pc(pc), .itlbpa(itlbpa), .icfill(icfill),
    .icinstr(icinstr), .ictag(ictag), .icbusy(icbusy), .icerror(icerror),
    .memreq(memreq), .memaddr(memaddr), .memack(memack),
    .memrdata(memrdata), .memerr(memerr)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: cache contents as the fill rules say they should be.
  logic [31:0] m_data [1024];
  bit          m_known [1024];
  bit          m_valid [128];
  logic [19:0] m_tag [128];

  logic [31:0] seen_addr [$];
  int          beats_done;
  int          stable_err;
  int          valid_leak;
  bit          timed_out;
  bit          hold_fill = 1'b0;
  logic [26:0] cur_line;

  task automatic clear_status();
    seen_addr.delete();
    beats_done = 0;
    stable_err = 0;
    valid_leak = 0;
    timed_out  = 1'b0;
  endtask

  task automatic set_pc(input logic [6:0] idx, input logic [2:0] w);
    pc = {$urandom, $urandom};
    pc[11:5] = idx;
    pc[4:2]  = w;
  endtask

  task automatic start_fill(input logic [6:0] idx, input logic [31:0] pav);
    @(negedge clk);
    set_pc(idx, 3'd0);
    itlbpa = pav;
    icfill = 1'b1;
    cur_line = {pav[31:12], idx};
    m_valid[idx] = 1'b0;
    clear_status();
    @(negedge clk);
    if (!hold_fill) icfill = 1'b0;
  endtask

  // Answers beats until the line completes, errors at errbeat, or stops before stopbeat.
  task automatic serve_beats(input int errbeat, input int stopbeat, input int waitc,
                             input logic [31:0] base, input bit fixed);
    int n;
    logic [31:0] a0;
    logic [31:0] word;
    logic [9:0] wa;
    for (int b = 0; b < 8; b++) begin
      if (b == stopbeat) return;
      n = 0;
      while (memreq !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (memreq !== 1'b1) begin
        timed_out = 1'b1;
        return;
      end
      seen_addr.push_back(memaddr);
      a0 = memaddr;
      if (ictag[20] !== 1'b0) valid_leak++;
      for (int k = 0; k < waitc; k++) begin
        @(negedge clk);
        if (memreq !== 1'b1 || memaddr !== a0) stable_err++;
        if (ictag[20] !== 1'b0) valid_leak++;
      end
      word = fixed ? base + 32'(b) : $urandom;
      memack = 1'b1;
      memrdata = word;
      memerr = (b == errbeat);
      @(negedge clk);
      memack = 1'b0;
      memerr = 1'b0;
      memrdata = $urandom;
      if (b == errbeat) return;
      wa = {cur_line[6:0], 3'(b)};
      m_data[wa] = word;
      m_known[wa] = 1'b1;
      beats_done++;
    end
    m_valid[cur_line[6:0]] = 1'b1;
    m_tag[cur_line[6:0]] = cur_line[26:7];
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    total_cnt++;
    if (icinstr !== 32'd0) $display("[TB] FAIL reset_icinstr: got %h expected 0", icinstr);
    else pass_cnt++;
    total_cnt++;
    if (ictag !== 21'd0) $display("[TB] FAIL reset_ictag: got %h expected 0", ictag);
    else pass_cnt++;
    total_cnt++;
    if (icerror !== 1'b0 || memreq !== 1'b0) $display("[TB] FAIL reset_flags: got err=%b req=%b expected 0 0", icerror, memreq);
    else pass_cnt++;
    n = 0;
    while (icbusy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    total_cnt++;
    if (n !== 128) $display("[TB] FAIL init_busy_cycles: got %0d expected 128", n);
    else pass_cnt++;
    for (int i = 0; i < 128; i++) begin
      set_pc(7'(i), 3'($urandom_range(0, 7)));
      @(negedge clk);
      total_cnt++;
      if (ictag[20] !== 1'b0) $display("[TB] FAIL init_valid idx %0d: got %b expected 0", i, ictag[20]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_fill();
    start_fill(7'd2, 32'h12345040);
    pc[63:12] = 52'hABCDE_0000_1234;
    serve_beats(-1, 8, 1, 32'hA0, 1'b1);
    total_cnt++;
    if (timed_out || beats_done !== 8) $display("[TB] FAIL clean_beats: got %0d timeout=%0b expected 8", beats_done, timed_out);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= seen_addr.size()) $display("[TB] FAIL clean_addr %0d: got none expected %h", i, 32'h12345040 + 4 * i);
      else if (seen_addr[i] !== 32'h12345040 + 32'(4 * i)) $display("[TB] FAIL clean_addr %0d: got %h expected %h", i, seen_addr[i], 32'h12345040 + 4 * i);
      else pass_cnt++;
    end
    total_cnt++;
    if (stable_err !== 0 || valid_leak !== 0) $display("[TB] FAIL clean_hold: got unstable=%0d leak=%0d expected 0 0", stable_err, valid_leak);
    else pass_cnt++;
    total_cnt++;
    if (memreq !== 1'b0 || icbusy !== 1'b0) $display("[TB] FAIL clean_done: got req=%b busy=%b expected 0 0", memreq, icbusy);
    else pass_cnt++;
    set_pc(7'd2, 3'd2);
    @(negedge clk);
    total_cnt++;
    if (ictag !== 21'h112345) $display("[TB] FAIL clean_tag: got %h expected 112345", ictag);
    else pass_cnt++;
    total_cnt++;
    if (icinstr !== 32'hA2) $display("[TB] FAIL clean_instr: got %h expected 000000a2", icinstr);
    else pass_cnt++;
  endtask

  task automatic test_bus_error();
    logic [6:0] idx;
    idx = 7'($urandom_range(8, 127));
    start_fill(idx, $urandom);
    serve_beats(3, 8, 1, 32'd0, 1'b0);
    total_cnt++;
    if (icerror !== 1'b1 || icbusy !== 1'b1 || memreq !== 1'b0 || beats_done !== 3)
      $display("[TB] FAIL err_state: got err=%b busy=%b req=%b beats=%0d expected 1 1 0 3", icerror, icbusy, memreq, beats_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (icbusy !== 1'b0 || icerror !== 1'b1 || ictag[20] !== 1'b0)
      $display("[TB] FAIL err_idle: got busy=%b err=%b valid=%b expected 0 1 0", icbusy, icerror, ictag[20]);
    else pass_cnt++;
    for (int w = 0; w < 3; w++) begin
      set_pc(idx, 3'(w));
      @(negedge clk);
      total_cnt++;
      if (icinstr !== m_data[{idx, 3'(w)}]) $display("[TB] FAIL err_word %0d: got %h expected %h", w, icinstr, m_data[{idx, 3'(w)}]);
      else pass_cnt++;
    end
    start_fill(idx, $urandom);
    total_cnt++;
    if (icerror !== 1'b0 || memreq !== 1'b1) $display("[TB] FAIL err_clear: got err=%b req=%b expected 0 1", icerror, memreq);
    else pass_cnt++;
    serve_beats(-1, 8, 0, 32'd0, 1'b0);
    total_cnt++;
    if (ictag !== {1'b1, m_tag[idx]}) $display("[TB] FAIL err_refill_tag: got %h expected %h", ictag, {1'b1, m_tag[idx]});
    else pass_cnt++;
  endtask

  task automatic test_held_fill();
    logic [6:0] idx;
    idx = 7'($urandom_range(8, 127));
    hold_fill = 1'b1;
    start_fill(idx, $urandom);
    serve_beats(-1, 8, 1, 32'd0, 1'b0);
    total_cnt++;
    if (seen_addr.size() !== 8 || memreq !== 1'b0 || icbusy !== 1'b0)
      $display("[TB] FAIL held_single: got beats=%0d req=%b busy=%b expected 8 0 0", seen_addr.size(), memreq, icbusy);
    else pass_cnt++;
    @(negedge clk);
    m_valid[idx] = 1'b0;
    clear_status();
    icfill = 1'b0;
    hold_fill = 1'b0;
    total_cnt++;
    if (memreq !== 1'b1 || memaddr !== {cur_line, 5'd0}) $display("[TB] FAIL held_second: got req=%b addr=%h expected 1 %h", memreq, memaddr, {cur_line, 5'd0});
    else pass_cnt++;
    serve_beats(-1, 8, 1, 32'd0, 1'b0);
    total_cnt++;
    if (beats_done !== 8 || ictag !== {1'b1, m_tag[idx]}) $display("[TB] FAIL held_done: got beats=%0d tag=%h expected 8 %h", beats_done, ictag, {1'b1, m_tag[idx]});
    else pass_cnt++;
  endtask

  task automatic test_replace();
    start_fill(7'd2, 32'h00001000);
    serve_beats(-1, 8, 0, 32'd0, 1'b0);
    total_cnt++;
    if (ictag !== 21'h100001) $display("[TB] FAIL replace_first: got %h expected 100001", ictag);
    else pass_cnt++;
    start_fill(7'd2, 32'h00002000);
    serve_beats(-1, 8, 2, 32'd0, 1'b0);
    set_pc(7'd2, 3'd6);
    @(negedge clk);
    total_cnt++;
    if (ictag !== 21'h100002) $display("[TB] FAIL replace_tag: got %h expected 100002", ictag);
    else pass_cnt++;
    total_cnt++;
    if (icinstr !== m_data[{7'd2, 3'd6}]) $display("[TB] FAIL replace_word: got %h expected %h", icinstr, m_data[{7'd2, 3'd6}]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    int n;
    start_fill(7'd2, 32'h0ABCD000);
    serve_beats(-1, 5, 1, 32'd0, 1'b0);
    total_cnt++;
    if (memreq !== 1'b1 || memaddr !== {cur_line, 3'd5, 2'b00}) $display("[TB] FAIL mid_beat5: got req=%b addr=%h expected 1 %h", memreq, memaddr, {cur_line, 3'd5, 2'b00});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    total_cnt++;
    if (memreq !== 1'b0 || icbusy !== 1'b1) $display("[TB] FAIL mid_reset: got req=%b busy=%b expected 0 1", memreq, icbusy);
    else pass_cnt++;
    memack = 1'b1;
    memrdata = ~m_data[{7'd2, 3'd5}];
    n = 0;
    while (icbusy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
      memack = 1'b0;
    end
    total_cnt++;
    if (n !== 128) $display("[TB] FAIL mid_init_cycles: got %0d expected 128", n);
    else pass_cnt++;
    for (int w = 0; w < 6; w++) begin
      set_pc(7'd2, 3'(w));
      @(negedge clk);
      total_cnt++;
      if (icinstr !== m_data[{7'd2, 3'(w)}] || ictag[20] !== 1'b0)
        $display("[TB] FAIL mid_word %0d: got %h valid=%b expected %h 0", w, icinstr, ictag[20], m_data[{7'd2, 3'(w)}]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] lines [$];
    logic [6:0] idx;
    logic [2:0] w;
    int eb;
    for (int r = 0; r < 8; r++) begin
      idx = 7'($urandom_range(0, 127));
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      start_fill(idx, $urandom);
      serve_beats(eb, 8, int'($urandom_range(0, 2)), 32'd0, 1'b0);
      total_cnt++;
      if (timed_out || stable_err !== 0 || valid_leak !== 0)
        $display("[TB] FAIL rand_fill %0d: got timeout=%0b unstable=%0d leak=%0d expected 0 0 0", r, timed_out, stable_err, valid_leak);
      else pass_cnt++;
      lines.push_back(idx);
    end
    @(negedge clk);
    for (int r = 0; r < 24; r++) begin
      idx = ($urandom_range(0, 3) != 0) ? lines[$urandom_range(0, lines.size() - 1)] : 7'($urandom_range(0, 127));
      w = 3'($urandom_range(0, 7));
      set_pc(idx, w);
      @(negedge clk);
      total_cnt++;
      if (m_valid[idx] ? (ictag !== {1'b1, m_tag[idx]}) : (ictag[20] !== 1'b0))
        $display("[TB] FAIL rand_tag idx %0d: got %h expected valid=%0b tag=%h", idx, ictag, m_valid[idx], m_tag[idx]);
      else pass_cnt++;
      if (m_known[{idx, w}]) begin
        total_cnt++;
        if (icinstr !== m_data[{idx, w}]) $display("[TB] FAIL rand_word %0d/%0d: got %h expected %h", idx, w, icinstr, m_data[{idx, w}]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    pc = 64'd0;
    itlbpa = 32'd0;
    icfill = 1'b0;
    memack = 1'b0;
    memrdata = 32'd0;
    memerr = 1'b0;
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_clean_fill();
    test_bus_error();
    test_held_fill();
    test_replace();
    test_reset_mid_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
